// File: rtl/clk_ratio_det.sv
// Measures the period of i_meas_clk in i_ref_clk cycles and reports lock and overflow status.
// Define CLK_RATIO_DET_DUTY_MEAS_EN to add o_high_cnt, the synchronized-high cycles per reported period.
module clk_ratio_det #(
  parameter int RATIO_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_meas_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic                   o_valid,
  output logic                   o_locked,
  output logic                   o_overflow
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
  ,
  output logic [RATIO_WIDTH-1:0] o_high_cnt
`endif
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);
  localparam logic [MW-1:0]          MATCH_FULL = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   meas_d;
  logic                   meas_s;
  logic                   meas_rise;
  logic [RATIO_WIDTH-1:0] cnt, cnt_nxt;
  logic [RATIO_WIDTH-1:0] ratio_nxt;
  logic                   valid_nxt, locked_nxt, ovf_nxt;
  logic [MW-1:0]          match, match_nxt;
  logic                   first, first_nxt;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
  logic [RATIO_WIDTH-1:0] high, high_nxt, high_out_nxt;
`endif

  assign meas_s    = sync_q[SYNC_STAGES-1];
  assign meas_rise = meas_s & ~meas_d;

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      meas_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_meas_clk};
      meas_d <= meas_s;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ratio_nxt  = o_ratio;
    valid_nxt  = 1'b0;
    locked_nxt = o_locked;
    ovf_nxt    = o_overflow;
    match_nxt  = match;
    first_nxt  = first;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
    high_nxt     = high;
    high_out_nxt = o_high_cnt;
`endif
    if (!i_en) begin
      // Leaving enable wins over any edge seen this cycle; the partial period is dropped.
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      locked_nxt = 1'b0;
      ovf_nxt    = 1'b0;
      match_nxt  = '0;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
      high_nxt   = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
          high_nxt  = '0;
`endif
        end
        ARM: begin
          if (meas_rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_ONE;
            first_nxt = 1'b1;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
            high_nxt  = CNT_ONE;
`endif
          end else if (cnt == CNT_MAX) begin
            // A static input never reaches MEASURE, so ARM times out too.
            ovf_nxt    = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        MEASURE: begin
          if (meas_rise) begin
            valid_nxt = 1'b1;
            ratio_nxt = cnt;
            cnt_nxt   = CNT_ONE;
            first_nxt = 1'b0;
            if (!first && (cnt == o_ratio))
              match_nxt = (match == MATCH_FULL) ? match : match + MW'(1);
            else
              match_nxt = '0;
            locked_nxt = (match_nxt == MATCH_FULL);
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
            high_out_nxt = high;
            high_nxt     = CNT_ONE;
`endif
          end else if (cnt == CNT_MAX) begin
            state_nxt  = ARM;
            ovf_nxt    = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            cnt_nxt    = '0;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
            high_nxt   = '0;
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
            high_nxt = high + RATIO_WIDTH'(meas_s);
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_ratio    <= '0;
      o_valid    <= 1'b0;
      o_locked   <= 1'b0;
      o_overflow <= 1'b0;
      match      <= '0;
      first      <= 1'b0;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
      high       <= '0;
      o_high_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      o_ratio    <= ratio_nxt;
      o_valid    <= valid_nxt;
      o_locked   <= locked_nxt;
      o_overflow <= ovf_nxt;
      match      <= match_nxt;
      first      <= first_nxt;
`ifdef CLK_RATIO_DET_DUTY_MEAS_EN
      high       <= high_nxt;
      o_high_cnt <= high_out_nxt;
`endif
    end
  end

endmodule
